// File: rtl/esp_uart_tx_if.sv
// esp_uart_tx_if: CPU-side write and status bundle for the ESP32 UART transmitter
interface esp_uart_tx_if;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       ovf_clr;
  logic       break_req;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       tx_busy;
  modport master (
    output wr_data, wr_en, ovf_clr, break_req,
    input  fifo_full, fifo_count, overflow, tx_busy
  );
  modport slave (
    input  wr_data, wr_en, ovf_clr, break_req,
    output fifo_full, fifo_count, overflow, tx_busy
  );
endinterface

// File: rtl/esp_uart_tx.sv
// esp_uart_tx: 16-byte FIFO feeding an 8N1 serializer with CTS gating; define ESP_UART_TX_BREAK_EN for break/mark support
module esp_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  esp_uart_tx_if.slave bus,
  input  logic         esp_cts,
  output logic         esp_tx
);
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef ESP_UART_TX_BREAK_EN
    , BREAK, MARK
`endif
  } state_t;
  state_t      state;
  logic [7:0]  mem [16];
  logic [3:0]  wp, rp;
  logic [4:0]  count;
  logic        ovf, cts_m, cts_s;
  logic [15:0] timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  sh;
  logic        full, wr, decide, go, pop, brk;
  assign full = count[4];
  assign wr   = bus.wr_en && !full;
  assign go   = count != 5'd0 && cts_s && !brk;
  assign pop  = decide && go;
`ifdef ESP_UART_TX_BREAK_EN
  assign brk    = bus.break_req;
  assign decide = state == IDLE || (timer == 16'd0 && (state == STOP || state == MARK));
`else
  logic unused_break;
  assign unused_break = bus.break_req;
  assign brk    = 1'b0;
  assign decide = state == IDLE || (timer == 16'd0 && state == STOP);
`endif
  assign bus.fifo_full  = full;
  assign bus.fifo_count = count;
  assign bus.overflow   = ovf;
  assign bus.tx_busy    = state != IDLE || count != 5'd0;
  // two-flop synchronizer for the asynchronous CTS pin
  always_ff @(posedge clk)
    if (reset) begin
      cts_m <= 1'b0;
      cts_s <= 1'b0;
    end else begin
      cts_m <= esp_cts;
      cts_s <= cts_m;
    end
  // FIFO storage, pointers, occupancy and sticky overflow (set wins over clear)
  always_ff @(posedge clk)
    if (reset) begin
      wp    <= 4'd0;
      rp    <= 4'd0;
      count <= 5'd0;
      ovf   <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= bus.wr_data;
        wp      <= wp + 4'd1;
      end
      if (pop) rp <= rp + 4'd1;
      count <= count + {4'd0, wr} - {4'd0, pop};
      ovf   <= (bus.wr_en && full) || (ovf && !bus.ovf_clr);
    end
  // frame sequencer; the idle decision also runs on the last stop/mark clock so frames abut
  always_ff @(posedge clk)
    if (reset) begin
      state   <= IDLE;
      esp_tx  <= 1'b1;
      timer   <= 16'd0;
      bit_cnt <= 3'd0;
      sh      <= 8'd0;
    end else if (decide) begin
`ifdef ESP_UART_TX_BREAK_EN
      if (brk) begin
        state  <= BREAK;
        esp_tx <= 1'b0;
      end else
`endif
      if (go) begin
        state  <= START;
        esp_tx <= 1'b0;
        sh     <= mem[rp];
        timer  <= RELOAD;
      end else begin
        state  <= IDLE;
        esp_tx <= 1'b1;
      end
    end else begin
      case (state)
        START:
          if (timer != 16'd0) timer <= timer - 16'd1;
          else begin
            state   <= DATA;
            esp_tx  <= sh[0];
            sh      <= sh >> 1;
            bit_cnt <= 3'd0;
            timer   <= RELOAD;
          end
        DATA:
          if (timer != 16'd0) timer <= timer - 16'd1;
          else if (bit_cnt == 3'd7) begin
            state  <= STOP;
            esp_tx <= 1'b1;
            timer  <= RELOAD;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            esp_tx  <= sh[0];
            sh      <= sh >> 1;
            timer   <= RELOAD;
          end
`ifdef ESP_UART_TX_BREAK_EN
        BREAK:
          if (!brk) begin
            state  <= MARK;
            esp_tx <= 1'b1;
            timer  <= RELOAD;
          end
`endif
        default: timer <= timer - 16'd1;
      endcase
    end
endmodule

// File: tb/tb_esp_uart_tx.sv
// tb_esp_uart_tx: vector table, directed corner sequences and random traffic against a frame-level model
module tb_esp_uart_tx;
  logic clk = 1'b0, reset = 1'b1, esp_cts = 1'b0, esp_tx;
  esp_uart_tx_if bus();
  esp_uart_tx #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .esp_cts(esp_cts), .esp_tx(esp_tx)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tests = 0, fails = 0, glitches = 0;
  bit mon_en = 1'b0;
  typedef struct {int t; logic [9:0] ln;} frame_t;
  frame_t rx_q[$];
  typedef struct {logic [7:0] d; logic [9:0] ln;} vec_t;
  vec_t vt[8];
  logic [7:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_data = d;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output int e);
    int s0;
    s0 = cyc;
    while (bus.tx_busy !== 1'b0 && cyc - s0 < lim) tick();
    check("idle_timeout", bus.tx_busy, 0);
    e = cyc;
  endtask

  // line monitor: each bit must hold steady for all 16 clocks; stop bit must be high
  initial begin : monitor
    frame_t f;
    bit ok, ab;
    forever begin
      @(negedge clk);
      if (mon_en && esp_tx === 1'b0) begin
        f.t = cyc;
        f.ln = '0;
        ok = 1'b1;
        ab = 1'b0;
        for (int s = 0; s < 160; s++) begin
          if (s > 0) @(negedge clk);
          if (!mon_en) begin
            ab = 1'b1;
            break;
          end
          if (s % 16 == 0) f.ln[s/16] = esp_tx;
          else if (esp_tx !== f.ln[s/16]) ok = 1'b0;
        end
        if (!ab) begin
          if (f.ln[9] !== 1'b1) ok = 1'b0;
          rx_q.push_back(f);
          glitches += ok ? 0 : 1;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, e, r, b, lowc, highc, mcnt, fc, pre;
    bit movf, dw, clr;
    logic [7:0] d;
    vt[0] = '{8'hA5, 10'b1101001010};
    vt[1] = '{8'h00, 10'b1000000000};
    vt[2] = '{8'hFF, 10'b1111111110};
    vt[3] = '{8'h55, 10'b1010101010};
    vt[4] = '{8'h3C, 10'b1001111000};
    vt[5] = '{8'hC3, 10'b1110000110};
    vt[6] = '{8'h01, 10'b1000000010};
    vt[7] = '{8'h80, 10'b1100000000};
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.ovf_clr = 1'b0; bus.break_req = 1'b0;
    repeat (3) tick();
    check("rst_tx", esp_tx, 1);
    check("rst_count", bus.fifo_count, 0);
    check("rst_full", bus.fifo_full, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_busy", bus.tx_busy, 0);
    reset = 1'b0;
    esp_cts = 1'b1;
    mon_en = 1'b1;
    repeat (4) tick();
    // single frames from the vector table
    for (int i = 0; i < 8; i++) begin
      rx_q.delete();
      wr(vt[i].d);
      n = cyc;
      check("single_count", bus.fifo_count, 1);
      wait_idle(400, e);
      check("single_busy_len", e - n, 161);
      check("single_frames", rx_q.size(), 1);
      if (rx_q.size() > 0) begin
        check("single_line", rx_q[0].ln, vt[i].ln);
        check("single_latency", rx_q[0].t - n, 1);
      end
    end
    // back-to-back writes produce abutting frames
    rx_q.delete();
    wr(8'h00); n = cyc;
    check("b2b_count1", bus.fifo_count, 1);
    wr(8'hFF);
    check("b2b_count2", bus.fifo_count, 1);
    wr(8'h55);
    check("b2b_count3", bus.fifo_count, 2);
    wait_idle(1000, e);
    check("b2b_total", e - n, 481);
    check("b2b_frames", rx_q.size(), 3);
    for (int j = 0; j < 3 && j < rx_q.size(); j++) begin
      check("b2b_line", rx_q[j].ln, vt[j+1].ln);
      check("b2b_start", rx_q[j].t - n, 1 + 160 * j);
    end
    // overflow with CTS held low
    rx_q.delete();
    esp_cts = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 17; i++) begin
      wr(8'(8'h10 + i));
      if (i == 14) check("ovf_notfull15", bus.fifo_full, 0);
      if (i == 15) begin
        check("ovf_full16", bus.fifo_full, 1);
        check("ovf_count16", bus.fifo_count, 16);
        check("ovf_clear_before", bus.overflow, 0);
      end
    end
    check("ovf_set", bus.overflow, 1);
    check("ovf_count17", bus.fifo_count, 16);
    repeat (5) tick();
    check("ovf_line_idle", esp_tx, 1);
    check("ovf_no_frames", rx_q.size(), 0);
    esp_cts = 1'b1;
    wait_idle(16 * 160 + 50, e);
    check("ovf_frames", rx_q.size(), 16);
    for (int j = 0; j < rx_q.size(); j++) check("ovf_byte", rx_q[j].ln[8:1], 8'h10 + j);
    check("ovf_sticky", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", bus.overflow, 0);
    // CTS dropped mid-frame
    rx_q.delete();
    wr(8'h3C); n = cyc;
    wr(8'hC3);
    while (cyc < n + 1 + 72) tick();
    esp_cts = 1'b0;
    while (cyc < n + 1 + 160 + 100) tick();
    check("cts_hold_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) check("cts_first_line", rx_q[0].ln, vt[4].ln);
    check("cts_hold_count", bus.fifo_count, 1);
    check("cts_hold_tx", esp_tx, 1);
    r = cyc;
    esp_cts = 1'b1;
    while (rx_q.size() < 2 && cyc < r + 400) tick();
    check("cts_frames", rx_q.size(), 2);
    if (rx_q.size() > 1) begin
      check("cts_resume_lat", rx_q[1].t - r, 3);
      check("cts_second_line", rx_q[1].ln, vt[5].ln);
    end
    wait_idle(400, e);
    // break request while idle
    rx_q.delete();
`ifdef ESP_UART_TX_BREAK_EN
    mon_en = 1'b0;
    b = cyc;
    bus.break_req = 1'b1;
    lowc = 0;
    for (int k = 0; k < 500; k++) begin
      bus.wr_en = (k == 100);
      bus.wr_data = 8'h42;
      tick();
      lowc += (esp_tx === 1'b0) ? 1 : 0;
    end
    bus.wr_en = 1'b0;
    bus.break_req = 1'b0;
    check("brk_low", lowc, 500);
    check("brk_count", bus.fifo_count, 1);
    check("brk_busy", bus.tx_busy, 1);
    highc = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (esp_tx !== 1'b1) break;
      highc++;
      mon_en = 1'b1;
    end
    mon_en = 1'b1;
    check("brk_mark", highc, 16);
    wait_idle(400, e);
    check("brk_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) begin
      check("brk_line", rx_q[0].ln, 10'b1010000100);
      check("brk_start", rx_q[0].t - b, 517);
    end
`else
    bus.break_req = 1'b1;
    wr(8'h42); n = cyc;
    wait_idle(400, e);
    bus.break_req = 1'b0;
    check("brk_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) begin
      check("brk_line", rx_q[0].ln, 10'b1010000100);
      check("brk_start", rx_q[0].t - n, 1);
    end
`endif
    // reset during a data bit with bytes queued
    rx_q.delete();
    wr(8'h11); n = cyc;
    wr(8'h22);
    wr(8'h33);
    while (cyc < n + 1 + 40) tick();
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_tx", esp_tx, 1);
    check("rstmid_count", bus.fifo_count, 0);
    check("rstmid_busy", bus.tx_busy, 0);
    lowc = 0;
    repeat (400) begin
      tick();
      lowc += (esp_tx === 1'b0) ? 1 : 0;
    end
    check("rstmid_quiet", lowc, 0);
    mon_en = 1'b1;
    // random traffic against a frame-level occupancy model
    rx_q.delete();
    exp_q.delete();
    mcnt = 0; fc = 0; movf = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) esp_cts = ($urandom_range(0, 3) != 0);
      dw = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 40) == 0);
      d = 8'($urandom);
      bus.wr_en = dw; bus.wr_data = d; bus.ovf_clr = clr;
      pre = mcnt;
      tick();
      if (dw && pre < 16) begin
        mcnt++;
        exp_q.push_back(d);
      end
      movf = (dw && pre == 16) || (movf && !clr);
      if (fc > 0) fc--;
      else if (esp_tx === 1'b0) begin
        mcnt--;
        fc = 159;
      end
      check("rnd_count", bus.fifo_count, mcnt);
      check("rnd_full", bus.fifo_full, mcnt == 16);
      check("rnd_ovf", bus.overflow, movf);
    end
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
    esp_cts = 1'b1;
    wait_idle(20 * 160 + 100, e);
    check("rnd_frames", rx_q.size(), exp_q.size());
    for (int j = 0; j < rx_q.size() && j < exp_q.size(); j++) check("rnd_byte", rx_q[j].ln[8:1], exp_q[j]);
    check("frame_shape", glitches, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
